// File: rtl/cpu_wr_dispatch.sv
// Z80 write-cycle dispatcher: detects memory/IO writes, latches address and data,
// issues one-cycle write strobes per target and holds WAIT while slow targets acknowledge.
module cpu_wr_dispatch #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  output logic        wait_n,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic        ga_we,
  output logic        crtc_we,
  output logic        romsel_we,
  output logic        pio8255_we,
  output logic        io_we,
  input  logic        io_ack,
  output logic        wr_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_mreq_sync;
  logic [SYNC_STAGES-1:0] r_iorq_sync;
  logic [SYNC_STAGES-1:0] r_m1_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;

  logic             r_wr_prev;
  logic             r_armed;
  logic [1:0]       r_mask;
  logic [TMO_W-1:0] r_tmo;
  logic             r_wait_n;
  logic             r_wr_err;
  logic [15:0]      r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_ram_we;
  logic [4:0]       r_io_we;

  logic       w_mreq_s;
  logic       w_iorq_s;
  logic       w_m1_s;
  logic       w_wr_s;
  logic       w_start;
  logic       w_is_mem;
  logic [4:0] w_io_dec;
  logic [4:0] w_io_sel;
  logic [1:0] w_mask_dec;
  logic [1:0] w_mask_nxt;
  logic       w_busy;
  logic       w_done;
  logic       w_abort;

  // The wr_n chain resets low so a write already in progress at reset release
  // cannot look like a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mreq_sync <= '1;
      r_iorq_sync <= '1;
      r_m1_sync   <= '1;
      r_wr_sync   <= '0;
    end else begin
      r_mreq_sync[0] <= mreq_n;
      r_iorq_sync[0] <= iorq_n;
      r_m1_sync[0]   <= m1_n;
      r_wr_sync[0]   <= wr_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_mreq_sync[i] <= r_mreq_sync[i-1];
        r_iorq_sync[i] <= r_iorq_sync[i-1];
        r_m1_sync[i]   <= r_m1_sync[i-1];
        r_wr_sync[i]   <= r_wr_sync[i-1];
      end
    end
  end

  assign w_mreq_s = r_mreq_sync[SYNC_STAGES-1];
  assign w_iorq_s = r_iorq_sync[SYNC_STAGES-1];
  assign w_m1_s   = r_m1_sync[SYNC_STAGES-1];
  assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_prev <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_wr_prev <= w_wr_s;
      if (w_wr_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Interrupt acknowledge (IORQ with M1) and contended requests never start a write.
  assign w_start = (r_state == S_IDLE) && r_armed && r_wr_prev && !w_wr_s &&
                   (w_mreq_s ^ w_iorq_s) && (w_iorq_s || w_m1_s);

  assign w_is_mem = !w_mreq_s;

  // IO targets decode from partial address bits: {io, pio, romsel, crtc, ga}
  assign w_io_dec   = {~A[10], ~A[11], ~A[13], ~A[14], ~A[15] & A[14]};
  assign w_io_sel   = w_is_mem ? 5'b0 : w_io_dec;
  assign w_mask_dec = {w_io_sel[4], w_is_mem};

  assign w_busy     = (r_state == S_STROBE) || (r_state == S_ACK);
  assign w_mask_nxt = r_mask & ~{io_ack, ram_ack};
  assign w_done     = w_busy && (w_mask_nxt == 2'b00);
  assign w_abort    = w_busy && !w_done && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE, S_ACK: begin
        if (w_done || w_abort) begin
          w_state_nxt = S_RELEASE;
        end else begin
          w_state_nxt = S_ACK;
        end
      end
      S_RELEASE: begin
        if (w_wr_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered on the start edge, so they are high only in STROBE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram_we  <= 1'b0;
      r_io_we   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_io_we  <= '0;
      if (w_start) begin
        r_ram_we  <= w_is_mem;
        r_io_we   <= w_io_sel;
        r_wr_addr <= A;
        r_wr_data <= D;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask   <= '0;
      r_tmo    <= '0;
      r_wait_n <= 1'b1;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      if (w_start) begin
        r_mask   <= w_mask_dec;
        r_tmo    <= '0;
        r_wait_n <= (w_mask_dec == 2'b00);
      end else if (w_busy) begin
        r_mask <= w_mask_nxt;
        r_tmo  <= r_tmo + 1'b1;
        if (w_done) begin
          r_wait_n <= 1'b1;
        end else if (w_abort) begin
          r_wait_n <= 1'b1;
          r_wr_err <= 1'b1;
          r_mask   <= '0;
        end
      end
    end
  end

  assign wait_n     = r_wait_n;
  assign wr_err     = r_wr_err;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign ram_we     = r_ram_we;
  assign ga_we      = r_io_we[0];
  assign crtc_we    = r_io_we[1];
  assign romsel_we  = r_io_we[2];
  assign pio8255_we = r_io_we[3];
  assign io_we      = r_io_we[4];

endmodule

// File: tb/tb_cpu_wr_dispatch.sv
// Directed self-checking bench for cpu_wr_dispatch: decode, wait/ack handshake,
// timeout, mid-cycle reset and rejected bus cycles.
module tb_cpu_wr_dispatch;

  localparam int SYNC_STAGES = 2;
  localparam int ACK_TIMEOUT = 255;
  localparam int TMO_W       = 8;
  localparam int LAT         = SYNC_STAGES + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, m1_n, wr_n;
  logic [15:0] A;
  logic [7:0]  D;
  logic        wait_n;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        ram_we, ram_ack, ga_we, crtc_we, romsel_we, pio8255_we, io_we, io_ack, wr_err;

  int total = 0;
  int bad   = 0;

  int n_ram, n_ga, n_crtc, n_rom, n_pio, n_io, n_err;
  int first_stb, err_cyc, wait_lo, wait_first;
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;

  cpu_wr_dispatch #(
    .SYNC_STAGES(SYNC_STAGES),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TMO_W      (TMO_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .m1_n      (m1_n),
    .wr_n      (wr_n),
    .A         (A),
    .D         (D),
    .wait_n    (wait_n),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_we    (ram_we),
    .ram_ack   (ram_ack),
    .ga_we     (ga_we),
    .crtc_we   (crtc_we),
    .romsel_we (romsel_we),
    .pio8255_we(pio8255_we),
    .io_we     (io_we),
    .io_ack    (io_ack),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  // Drives one CPU write and records per-cycle observations; cycle 1 is the
  // first rising edge after wr_n goes low. ram_dly/io_dly < 0 means never ack.
  task automatic run_write(input logic use_mreq, input logic use_iorq, input logic m1_lo,
                           input logic [15:0] addr, input logic [7:0] data,
                           input int ram_dly, input int io_dly, input int hold);
    n_ram = 0; n_ga = 0; n_crtc = 0; n_rom = 0; n_pio = 0; n_io = 0; n_err = 0;
    first_stb = -1; err_cyc = -1; wait_lo = 0; wait_first = -1;
    cap_addr = '0; cap_data = '0;
    A = addr; D = data;
    mreq_n = ~use_mreq; iorq_n = ~use_iorq; m1_n = ~m1_lo;
    @(posedge clk); #1;
    wr_n = 1'b0;
    for (int cyc = 1; cyc <= hold + 6; cyc++) begin
      @(posedge clk); #1;
      if ((ram_we | ga_we | crtc_we | romsel_we | pio8255_we | io_we) === 1'b1 && first_stb < 0) begin
        first_stb = cyc;
        cap_addr  = wr_addr;
        cap_data  = wr_data;
      end
      if (ram_we === 1'b1)     n_ram++;
      if (ga_we === 1'b1)      n_ga++;
      if (crtc_we === 1'b1)    n_crtc++;
      if (romsel_we === 1'b1)  n_rom++;
      if (pio8255_we === 1'b1) n_pio++;
      if (io_we === 1'b1)      n_io++;
      if (wr_err === 1'b1) begin
        n_err++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (wait_n !== 1'b1) begin
        wait_lo++;
        if (wait_first < 0) wait_first = cyc;
      end
      ram_ack = (first_stb >= 0 && ram_dly >= 0 && cyc == first_stb + ram_dly);
      io_ack  = (first_stb >= 0 && io_dly >= 0 && cyc == first_stb + io_dly);
      if (cyc == hold) begin
        wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
      end
    end
    ram_ack = 1'b0;
    io_ack  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; wr_n = 1'b1;
    A = '0; D = '0; ram_ack = 1'b0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (wait_n !== 1'b1) begin bad++; $display("FAIL reset_wait_n got=%b want=1", wait_n); end
    total++;
    if ({ram_we, ga_we, crtc_we, romsel_we, pio8255_we, io_we, wr_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=0000000",
               {ram_we, ga_we, crtc_we, romsel_we, pio8255_we, io_we, wr_err});
    end
    total++;
    if (wr_addr !== 16'h0000) begin bad++; $display("FAIL reset_wr_addr got=%h want=0000", wr_addr); end
    total++;
    if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", wr_data); end
  endtask

  task automatic test_mem_write();
    run_write(1'b1, 1'b0, 1'b0, 16'h4000, 8'hA5, 3, -1, 10);
    total++;
    if (n_ram != 1) begin bad++; $display("FAIL mem_ram_we_count got=%0d want=1", n_ram); end
    total++;
    if (first_stb != LAT) begin bad++; $display("FAIL mem_latency got=%0d want=%0d", first_stb, LAT); end
    total++;
    if (cap_addr !== 16'h4000) begin bad++; $display("FAIL mem_wr_addr got=%h want=4000", cap_addr); end
    total++;
    if (cap_data !== 8'hA5) begin bad++; $display("FAIL mem_wr_data got=%h want=a5", cap_data); end
    total++;
    if (wait_first != LAT) begin bad++; $display("FAIL mem_wait_start got=%0d want=%0d", wait_first, LAT); end
    total++;
    if (wait_lo != 4) begin bad++; $display("FAIL mem_wait_len got=%0d want=4", wait_lo); end
    total++;
    if (n_ga + n_crtc + n_rom + n_pio + n_io + n_err != 0) begin
      bad++;
      $display("FAIL mem_other_strobes got=%0d want=0", n_ga + n_crtc + n_rom + n_pio + n_io + n_err);
    end
    total++;
    if (wr_addr !== 16'h4000) begin bad++; $display("FAIL mem_addr_hold got=%h want=4000", wr_addr); end
  endtask

  task automatic test_io_decode();
    logic [15:0] addrs [4];
    logic [7:0]  datas [4];
    logic [4:0]  exps  [4];
    logic [14:0] got, want;
    addrs = '{16'h7F00, 16'hBC00, 16'hDF00, 16'hF400};
    datas = '{8'h8C, 8'h0D, 8'h07, 8'h82};
    // {ga, crtc, romsel, pio, io}
    exps  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};
    for (int k = 0; k < 4; k++) begin
      run_write(1'b0, 1'b1, 1'b0, addrs[k], datas[k], -1, -1, 8);
      got  = {3'(n_ga), 3'(n_crtc), 3'(n_rom), 3'(n_pio), 3'(n_io)};
      want = {2'b0, exps[k][4], 2'b0, exps[k][3], 2'b0, exps[k][2], 2'b0, exps[k][1], 2'b0, exps[k][0]};
      total++;
      if (got !== want) begin bad++; $display("FAIL io_decode_%h got=%o want=%o", addrs[k], got, want); end
      total++;
      if (n_ram != 0 || wait_lo != 0) begin
        bad++;
        $display("FAIL io_nowait_%h got_ram=%0d got_wait_lo=%0d want=0", addrs[k], n_ram, wait_lo);
      end
      total++;
      if (cap_data !== datas[k]) begin bad++; $display("FAIL io_data_%h got=%h want=%h", addrs[k], cap_data, datas[k]); end
    end
  endtask

  task automatic test_io_multi();
    run_write(1'b0, 1'b1, 1'b0, 16'h0000, 8'hFF, -1, 2, 10);
    total++;
    if ({3'(n_ga), 3'(n_crtc), 3'(n_rom), 3'(n_pio), 3'(n_io)} !== 15'o01111) begin
      bad++;
      $display("FAIL io_multi_strobes got=%0d%0d%0d%0d%0d want=01111", n_ga, n_crtc, n_rom, n_pio, n_io);
    end
    total++;
    if (wait_first != LAT || wait_lo != 3) begin
      bad++;
      $display("FAIL io_multi_wait got_start=%0d got_len=%0d want_start=%0d want_len=3", wait_first, wait_lo, LAT);
    end
    total++;
    if (cap_addr !== 16'h0000 || cap_data !== 8'hFF) begin
      bad++;
      $display("FAIL io_multi_latch got=%h/%h want=0000/ff", cap_addr, cap_data);
    end
  endtask

  task automatic test_timeout();
    run_write(1'b1, 1'b0, 1'b0, 16'h8123, 8'h42, -1, -1, 400);
    total++;
    if (n_err != 1) begin bad++; $display("FAIL tmo_err_count got=%0d want=1", n_err); end
    total++;
    if (err_cyc != LAT + ACK_TIMEOUT) begin
      bad++;
      $display("FAIL tmo_err_cycle got=%0d want=%0d", err_cyc, LAT + ACK_TIMEOUT);
    end
    total++;
    if (wait_lo != ACK_TIMEOUT) begin bad++; $display("FAIL tmo_wait_len got=%0d want=%0d", wait_lo, ACK_TIMEOUT); end
    total++;
    if (n_ram != 1) begin bad++; $display("FAIL tmo_single_strobe got=%0d want=1", n_ram); end
    total++;
    if (wait_n !== 1'b1) begin bad++; $display("FAIL tmo_wait_release got=%b want=1", wait_n); end
  endtask

  task automatic test_reset_mid();
    int stb, wl;
    A = 16'h1234; D = 8'h5A; mreq_n = 1'b0; iorq_n = 1'b1; m1_n = 1'b1;
    @(posedge clk); #1;
    wr_n = 1'b0;
    stb = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ram_we === 1'b1) stb++;
    end
    total++;
    if (stb != 1 || wait_n !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre got_stb=%0d got_wait=%b want_stb=1 want_wait=0", stb, wait_n);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({wait_n, ram_we, wr_err} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b want=100", {wait_n, ram_we, wr_err});
    end
    total++;
    if (wr_addr !== 16'h0000 || wr_data !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_latch got=%h/%h want=0000/00", wr_addr, wr_data);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    stb = 0; wl = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ((ram_we | ga_we | crtc_we | romsel_we | pio8255_we | io_we) === 1'b1) stb++;
      if (wait_n !== 1'b1) wl++;
    end
    total++;
    if (stb != 0 || wl != 0) begin
      bad++;
      $display("FAIL rstmid_blocked got_stb=%0d got_wait_lo=%0d want=0", stb, wl);
    end
    wr_n = 1'b1; mreq_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_write(1'b1, 1'b0, 1'b0, 16'h2000, 8'h3C, 1, -1, 10);
    total++;
    if (n_ram != 1 || cap_addr !== 16'h2000 || wait_lo != 2) begin
      bad++;
      $display("FAIL rstmid_recover got_ram=%0d got_addr=%h got_wait_lo=%0d want=1/2000/2", n_ram, cap_addr, wait_lo);
    end
  endtask

  task automatic test_rejected();
    run_write(1'b0, 1'b1, 1'b1, 16'h0000, 8'h11, 0, 0, 8);
    total++;
    if (n_ram + n_ga + n_crtc + n_rom + n_pio + n_io != 0 || wait_lo != 0) begin
      bad++;
      $display("FAIL intack_no_write got_stb=%0d got_wait_lo=%0d want=0",
               n_ram + n_ga + n_crtc + n_rom + n_pio + n_io, wait_lo);
    end
    run_write(1'b1, 1'b1, 1'b0, 16'h0000, 8'h22, 0, 0, 8);
    total++;
    if (n_ram + n_ga + n_crtc + n_rom + n_pio + n_io != 0 || wait_lo != 0) begin
      bad++;
      $display("FAIL both_req_no_write got_stb=%0d got_wait_lo=%0d want=0",
               n_ram + n_ga + n_crtc + n_rom + n_pio + n_io, wait_lo);
    end
  endtask

  task automatic test_back_to_back();
    run_write(1'b1, 1'b0, 1'b0, 16'hC000, 8'h01, 0, -1, 6);
    run_write(1'b0, 1'b1, 1'b0, 16'h7F10, 8'h55, -1, -1, 6);
    total++;
    if (n_ga != 1 || n_ram != 0 || cap_addr !== 16'h7F10 || cap_data !== 8'h55) begin
      bad++;
      $display("FAIL b2b_second got_ga=%0d got_ram=%0d got=%h/%h want=1/0/7f10/55", n_ga, n_ram, cap_addr, cap_data);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_io_decode();
    test_io_multi();
    test_timeout();
    test_reset_mid();
    test_rejected();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
